// File: rtl/qtcore_scan_sequencer.sv
// qtcore_scan_sequencer
// Sequences the accumulator_microcontroller scan chain and run enable for a
// host: loads a full chain image, runs the core for a bounded number of
// cycles, and unloads the chain non-destructively by rotating it.
//
// Optional feature macro: SCAN_SEQ_HALT_STOP_EN
//   defined   -> RUN also ends on the edge where halt is sampled high
//   undefined -> halt only sets the sticky halted flag
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   cmd_valid/ready    host command handshake (ready only while IDLE)
//   cmd_op             00 LOAD, 01 RUN, 10 LOAD_RUN_UNLOAD, 11 UNLOAD
//   cmd_cycles         number of RUN cycles
//   load_data          chain image, MSB shifted first
//   unload_data        captured chain image, bit 0 captured last
//   done               one-cycle completion pulse
//   halted, cycles_run status of the last RUN phase
//   scan_enable, scan_in, scan_out, proc_en, halt   core-side pins
module qtcore_scan_sequencer #(
    parameter int unsigned CHAIN_LEN = 152,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_W-1:0]     cmd_cycles,
    input  logic [CHAIN_LEN-1:0] load_data,
    output logic [CHAIN_LEN-1:0] unload_data,
    output logic                 done,
    output logic                 halted,
    output logic [CNT_W-1:0]     cycles_run,
    output logic                 scan_enable,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 proc_en,
    input  logic                 halt
);

    localparam int unsigned BIT_W = $clog2(CHAIN_LEN + 1);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_LRU    = 2'b10;
    localparam logic [1:0] OP_UNLOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOAD   = 2'b01,
        S_RUN    = 2'b10,
        S_UNLOAD = 2'b11
    } state_t;

    state_t                 state;
    state_t                 state_d;
    logic                   done_d;
    logic [1:0]             op_q;
    logic [CNT_W-1:0]       cycles_q;
    logic [CHAIN_LEN-1:0]   sr;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   accept;
    logic                   last_bit;
    logic                   run_last;

    assign accept   = cmd_valid && (state == S_IDLE);
    assign last_bit = (bit_cnt == BIT_W'(CHAIN_LEN - 1));

`ifdef SCAN_SEQ_HALT_STOP_EN
    assign run_last = (CNT_W'(cycles_run + CNT_W'(1)) == cycles_q) || halt;
`else
    assign run_last = (CNT_W'(cycles_run + CNT_W'(1)) == cycles_q);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and completion decode
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD, OP_LRU: state_d = S_LOAD;
                        OP_RUN: begin
                            // A zero-length RUN completes at acceptance
                            if (cmd_cycles == '0) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        default: state_d = S_UNLOAD;
                    endcase
                end
            end
            S_LOAD: begin
                if (last_bit) begin
                    if (op_q != OP_LRU) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (cycles_q == '0) begin
                        state_d = S_UNLOAD;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (run_last) begin
                    if (op_q == OP_LRU) begin
                        state_d = S_UNLOAD;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_UNLOAD: begin
                if (last_bit) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs; in UNLOAD the chain is rotated through scan_out
    always_comb begin
        cmd_ready   = 1'b0;
        scan_enable = 1'b0;
        proc_en     = 1'b0;
        scan_in     = sr[CHAIN_LEN-1];
        case (state)
            S_IDLE:   cmd_ready = 1'b1;
            S_LOAD:   scan_enable = 1'b1;
            S_RUN:    proc_en = 1'b1;
            S_UNLOAD: begin
                scan_enable = 1'b1;
                scan_in     = scan_out;
            end
            default: ;
        endcase
    end

    // Command latch, shift register, bit counter and run status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_LOAD;
            cycles_q   <= '0;
            sr         <= '0;
            bit_cnt    <= '0;
            cycles_run <= '0;
            halted     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= done_d;
            if (accept) begin
                op_q       <= cmd_op;
                cycles_q   <= cmd_cycles;
                sr         <= load_data;
                bit_cnt    <= '0;
                cycles_run <= '0;
                halted     <= 1'b0;
            end else begin
                case (state)
                    S_LOAD, S_UNLOAD: begin
                        sr      <= {sr[CHAIN_LEN-2:0], scan_out};
                        bit_cnt <= last_bit ? '0 : BIT_W'(bit_cnt + BIT_W'(1));
                    end
                    S_RUN: begin
                        cycles_run <= CNT_W'(cycles_run + CNT_W'(1));
                        if (halt) begin
                            halted <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign unload_data = sr;

endmodule
